mcpu_scoreboard: RTL and testbench
==================================

Name: mcpu_scoreboard

Overview:
- Owns the register and predicate scoreboards that the decode stage reads to detect hazards.
- Marks a destination busy when decode issues an instruction that writes it. Clears it when a writeback port retires that write.
- Sits beside decode. Its outputs drive decode's reg_scoreboard and pred_scoreboard inputs.
- Tracks in-flight writes per register with small saturating counters, so overlapping long-latency (LSU) and short-latency (ALU) writes to the same register are handled correctly.

Parameters:
- WB_PORTS, 2, number of independent writeback/retire ports (port 0 = ALU/other, port 1 = LSU).
- CNT_W, 2, width of each per-register and per-predicate in-flight counter. Max count is 2^CNT_W-1.

Ports:
- clkrst_core_clk  input  1  core clock; all state changes on rising edge.
- clkrst_core_rst  input  1  asynchronous, active-high reset.
- iss_valid  input  1  decode issued an instruction this cycle (valid and not stalled).
- iss_rd_we  input  1  issued instruction writes GPR iss_rd_num.
- iss_rd_num  input  5  destination GPR.
- iss_pred_we  input  1  issued instruction writes a predicate.
- iss_pred_num  input  2  destination predicate; only 0..2 are valid.
- wb_valid  input  WB_PORTS  per-port GPR retire strobe.
- wb_num  input  5*WB_PORTS  per-port retired GPR; port p occupies bits [5p+4:5p].
- pwb_valid  input  WB_PORTS  per-port predicate retire strobe.
- pwb_num  input  2*WB_PORTS  per-port retired predicate.
- reg_scoreboard  output  32  bit r is set iff GPR r has a nonzero in-flight count.
- pred_scoreboard  output  3  bit p is set iff predicate p has a nonzero in-flight count.
- sb_err  output  1  sticky error flag, set on overflow or underflow.

Behaviour:
- Reset (async, any time including mid-operation): all counters go to 0, reg_scoreboard=0, pred_scoreboard=0, sb_err=0. Writebacks in flight at reset are forgotten. A retire that arrives after reset is an underflow, handled as below.
- State: 32 GPR counters and 3 predicate counters, each CNT_W bits.
- Outputs are pure functions of counter state (OR-reduce of each counter).
  - Issue-to-visible latency: 1 cycle. A bit set by an issue in cycle N is seen by decode in cycle N+1.
  - Retire-to-clear latency: 1 cycle.
  - No same-cycle bypass. Decode stalls one extra cycle after a retire.
- Per-cycle update for each GPR r:
  - inc = iss_valid & iss_rd_we & (iss_rd_num==r).
  - dec = number of ports p with wb_valid[p] & wb_num[p]==r (0..WB_PORTS).
  - next = count + inc - dec, computed at CNT_W+2 bits.
  - Simultaneous issue and retire of the same register nets out. Count 1 with inc=1 and dec=1 stays 1.
  - Two ports retiring the same register in the same cycle decrement by 2.
- Predicates: same rules using iss_pred_we/iss_pred_num and pwb_valid/pwb_num.
  - A predicate number of 3, on issue or retire, is ignored: no state change and no error. Predicate 3 is the hardwired-true predicate.
- Saturation and error:
  - If next < 0, the counter is set to 0 and sb_err is set.
  - If next > max, the counter is set to max and sb_err is set.
  - sb_err clears only on reset.
- iss_rd_we and iss_pred_we are both honoured if both are asserted.
- Strobes gated by iss_valid=0 or wb_valid=0 have no effect, regardless of the num fields.

Decomposition:
- Shared package/include "mcpu_sb.vh":
  - NUM_GPRS=32, NUM_PREDS=3, GPR_NUM_W=5, PRED_NUM_W=2.
  - PRED_ALWAYS=2'd3.
- Sub-module mcpu_sb_counter, instantiated 35 times. It holds one saturating up/down counter:
  - Inputs: inc (1 bit), dec (count of 0..WB_PORTS).
  - Outputs: busy, ovf, unf.
- The top level does decode of the issue and retire numbers, per-entry popcount of dec, the output OR, and the sticky error register.

Test Plan:
- Reset then issue r5 (iss_rd_we=1) in cycle 1:
  - reg_scoreboard==0x00000020 from cycle 2.
  - wb_valid[0], wb_num=5 in cycle 4 gives reg_scoreboard==0 in cycle 5.
  - sb_err=0 throughout.
- Issue r7 in cycle N, then issue r7 again plus wb port0 r7 in cycle N+1:
  - Bit 7 stays 1.
  - A single port1 retire of r7 in N+3 clears bit 7 in N+4.
- r9 at count 2; wb_valid=2'b11, wb_num={5'd9,5'd9} in one cycle:
  - Bit 9 clears the next cycle.
  - sb_err=0.
- Retire r3 with count 0:
  - Bit 3 stays 0.
  - sb_err=1 next cycle and stays 1 until reset.
  - Four issues of r3 (max=3) also set sb_err, and bit 3 stays set until 3 retires.
- Predicates:
  - Issue pred 1 gives pred_scoreboard==3'b010 next cycle.
  - Issue or retire of pred 3 leaves pred_scoreboard unchanged and sb_err=0.
  - pwb port1 pred 1 clears it.
- Async reset pulse mid-cycle with r0, r31 and pred 0 busy:
  - Outputs go to 0 immediately, without waiting for a clock edge.
  - A subsequent retire of r31 sets sb_err.

Source files
------------

// File: rtl/mcpu_scoreboard_pkg.sv
// Shared sizing constants for the register/predicate scoreboard.
package mcpu_scoreboard_pkg;

    localparam int unsigned NUM_GPRS   = 32;
    localparam int unsigned NUM_PREDS  = 3;
    localparam int unsigned GPR_NUM_W  = 5;
    localparam int unsigned PRED_NUM_W = 2;

    // Predicate 3 is hardwired true and never tracked.
    localparam logic [PRED_NUM_W-1:0] PRED_ALWAYS = 2'd3;

endpackage

// File: rtl/mcpu_scoreboard_if.sv
// Issue/retire strobes into the scoreboard and hazard bits back out to decode.
interface mcpu_scoreboard_if #(
    parameter int unsigned WB_PORTS = 2
);
    import mcpu_scoreboard_pkg::*;

    logic                             iss_valid;
    logic                             iss_rd_we;
    logic [GPR_NUM_W-1:0]             iss_rd_num;
    logic                             iss_pred_we;
    logic [PRED_NUM_W-1:0]            iss_pred_num;
    logic [WB_PORTS-1:0]              wb_valid;
    logic [GPR_NUM_W*WB_PORTS-1:0]    wb_num;
    logic [WB_PORTS-1:0]              pwb_valid;
    logic [PRED_NUM_W*WB_PORTS-1:0]   pwb_num;
    logic [NUM_GPRS-1:0]              reg_scoreboard;
    logic [NUM_PREDS-1:0]             pred_scoreboard;
    logic                             sb_err;

    modport master (
        output iss_valid, iss_rd_we, iss_rd_num, iss_pred_we, iss_pred_num,
        output wb_valid, wb_num, pwb_valid, pwb_num,
        input  reg_scoreboard, pred_scoreboard, sb_err
    );

    modport slave (
        input  iss_valid, iss_rd_we, iss_rd_num, iss_pred_we, iss_pred_num,
        input  wb_valid, wb_num, pwb_valid, pwb_num,
        output reg_scoreboard, pred_scoreboard, sb_err
    );

endinterface

// File: rtl/mcpu_sb_counter.sv
// One saturating in-flight write counter: +inc, -dec per cycle, clamps and flags.
module mcpu_sb_counter #(
    parameter int unsigned CNT_W = 2,
    parameter int unsigned DEC_W = 2
) (
    input  logic             clkrst_core_clk,
    input  logic             clkrst_core_rst,
    input  logic             inc,
    input  logic [DEC_W-1:0] dec,
    output logic             busy,
    output logic             ovf,
    output logic             unf
);

    // Two guard bits: one for overflow above max, one as sign for underflow.
    localparam int unsigned SUM_W = CNT_W + 2;
    localparam logic [SUM_W-1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SUM_W-1:0] sum;

    // Net the increment and decrements, then clamp into range.
    always_comb begin
        sum   = {2'b00, cnt_q} + SUM_W'(inc) - SUM_W'(dec);
        cnt_d = sum[CNT_W-1:0];
        ovf   = 1'b0;
        unf   = 1'b0;
        if (sum[SUM_W-1]) begin
            unf   = 1'b1;
            cnt_d = '0;
        end else if (sum > CNT_MAX) begin
            ovf   = 1'b1;
            cnt_d = '1;
        end
    end

    // Counter state.
    always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
        if (clkrst_core_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = |cnt_q;

endmodule

// File: rtl/mcpu_scoreboard.sv
// GPR and predicate busy scoreboard read by decode for hazard detection.
module mcpu_scoreboard
    import mcpu_scoreboard_pkg::*;
#(
    parameter int unsigned WB_PORTS = 2,
    parameter int unsigned CNT_W    = 2
) (
    input  logic           clkrst_core_clk,
    input  logic           clkrst_core_rst,
    mcpu_scoreboard_if.slave sb_if
);

    localparam int unsigned DEC_W = $clog2(WB_PORTS + 1);

    logic [NUM_GPRS-1:0]             gpr_inc, gpr_busy, gpr_ovf, gpr_unf;
    logic [NUM_GPRS-1:0][DEC_W-1:0]  gpr_dec;
    logic [NUM_PREDS-1:0]            pred_inc, pred_busy, pred_ovf, pred_unf;
    logic [NUM_PREDS-1:0][DEC_W-1:0] pred_dec;
    logic                            err_q, err_d;

    // Decode issue number into per-GPR increment; popcount matching retire ports.
    always_comb begin
        gpr_inc = '0;
        gpr_dec = '0;
        for (int r = 0; r < NUM_GPRS; r++) begin
            gpr_inc[r] = sb_if.iss_valid && sb_if.iss_rd_we &&
                         (sb_if.iss_rd_num == GPR_NUM_W'(r));
            for (int p = 0; p < WB_PORTS; p++) begin
                if (sb_if.wb_valid[p] &&
                    (sb_if.wb_num[p*GPR_NUM_W +: GPR_NUM_W] == GPR_NUM_W'(r))) begin
                    gpr_dec[r] = gpr_dec[r] + DEC_W'(1);
                end
            end
        end
    end

    // Same for predicates; PRED_ALWAYS never matches a tracked entry.
    always_comb begin
        pred_inc = '0;
        pred_dec = '0;
        for (int r = 0; r < NUM_PREDS; r++) begin
            pred_inc[r] = sb_if.iss_valid && sb_if.iss_pred_we &&
                          (sb_if.iss_pred_num != PRED_ALWAYS) &&
                          (sb_if.iss_pred_num == PRED_NUM_W'(r));
            for (int p = 0; p < WB_PORTS; p++) begin
                if (sb_if.pwb_valid[p] &&
                    (sb_if.pwb_num[p*PRED_NUM_W +: PRED_NUM_W] != PRED_ALWAYS) &&
                    (sb_if.pwb_num[p*PRED_NUM_W +: PRED_NUM_W] == PRED_NUM_W'(r))) begin
                    pred_dec[r] = pred_dec[r] + DEC_W'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_GPRS; g++) begin : g_gpr
        mcpu_sb_counter #(.CNT_W(CNT_W), .DEC_W(DEC_W)) u_cnt (
            .clkrst_core_clk (clkrst_core_clk),
            .clkrst_core_rst (clkrst_core_rst),
            .inc             (gpr_inc[g]),
            .dec             (gpr_dec[g]),
            .busy            (gpr_busy[g]),
            .ovf             (gpr_ovf[g]),
            .unf             (gpr_unf[g])
        );
    end

    for (genvar g = 0; g < NUM_PREDS; g++) begin : g_pred
        mcpu_sb_counter #(.CNT_W(CNT_W), .DEC_W(DEC_W)) u_cnt (
            .clkrst_core_clk (clkrst_core_clk),
            .clkrst_core_rst (clkrst_core_rst),
            .inc             (pred_inc[g]),
            .dec             (pred_dec[g]),
            .busy            (pred_busy[g]),
            .ovf             (pred_ovf[g]),
            .unf             (pred_unf[g])
        );
    end

    // Sticky error: any counter clamping this cycle latches it until reset.
    always_comb begin
        err_d = err_q | (|gpr_ovf) | (|gpr_unf) | (|pred_ovf) | (|pred_unf);
    end

    // Error flag register.
    always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
        if (clkrst_core_rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    // Outputs come straight from counter state, no same-cycle bypass.
    always_comb begin
        sb_if.reg_scoreboard  = gpr_busy;
        sb_if.pred_scoreboard = pred_busy;
        sb_if.sb_err          = err_q;
    end

endmodule

// File: tb/tb_mcpu_scoreboard.sv
// Directed scoreboard bench: driver pushes expected post-edge state, monitor pops and compares.
module tb_mcpu_scoreboard;

    logic clk;
    logic rst;

    mcpu_scoreboard_if #(.WB_PORTS(2)) sb_bus ();

    mcpu_scoreboard #(.WB_PORTS(2), .CNT_W(2)) dut (
        .clkrst_core_clk (clk),
        .clkrst_core_rst (rst),
        .sb_if           (sb_bus)
    );

    typedef struct {
        string       name;
        logic [31:0] regs;
        logic [2:0]  preds;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks;
    int   n_fail;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, want);
        end
    endtask

    // Monitor: after each rising edge, compare against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.name, ".reg"}, sb_bus.reg_scoreboard, e.regs);
                check({e.name, ".pred"}, {29'd0, sb_bus.pred_scoreboard}, {29'd0, e.preds});
                check({e.name, ".err"}, {31'd0, sb_bus.sb_err}, {31'd0, e.err});
            end
        end
    end

    task automatic drive_idle();
        sb_bus.iss_valid    = 1'b0;
        sb_bus.iss_rd_we    = 1'b0;
        sb_bus.iss_rd_num   = 5'd0;
        sb_bus.iss_pred_we  = 1'b0;
        sb_bus.iss_pred_num = 2'd0;
        sb_bus.wb_valid     = 2'b00;
        sb_bus.wb_num       = 10'd0;
        sb_bus.pwb_valid    = 2'b00;
        sb_bus.pwb_num      = 4'd0;
    endtask

    // One cycle of stimulus plus the state expected after the next rising edge.
    task automatic step(input string nm,
                        input logic iv, input logic rwe, input logic [4:0] rd,
                        input logic pwe, input logic [1:0] pn,
                        input logic [1:0] wbv, input logic [4:0] wb0, input logic [4:0] wb1,
                        input logic [1:0] pwbv, input logic [1:0] pw0, input logic [1:0] pw1,
                        input logic [31:0] ereg, input logic [2:0] epred, input logic eerr);
        exp_t e;
        @(negedge clk);
        sb_bus.iss_valid    = iv;
        sb_bus.iss_rd_we    = rwe;
        sb_bus.iss_rd_num   = rd;
        sb_bus.iss_pred_we  = pwe;
        sb_bus.iss_pred_num = pn;
        sb_bus.wb_valid     = wbv;
        sb_bus.wb_num       = {wb1, wb0};
        sb_bus.pwb_valid    = pwbv;
        sb_bus.pwb_num      = {pw1, pw0};
        e.name  = nm;
        e.regs  = ereg;
        e.preds = epred;
        e.err   = eerr;
        exp_q.push_back(e);
    endtask

    // Return to idle and let the monitor consume everything outstanding.
    task automatic drain();
        int budget;
        @(negedge clk);
        drive_idle();
        budget = 0;
        while (exp_q.size() > 0 && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Asynchronous reset pulse between edges; outputs must clear without a clock.
    task automatic async_reset(input string nm);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check({nm, ".reg"}, sb_bus.reg_scoreboard, 32'd0);
        check({nm, ".pred"}, {29'd0, sb_bus.pred_scoreboard}, 32'd0);
        check({nm, ".err"}, {31'd0, sb_bus.sb_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        drive_idle();
        rst = 1'b1;
        #3;
        check("por.reg", sb_bus.reg_scoreboard, 32'd0);
        check("por.pred", {29'd0, sb_bus.pred_scoreboard}, 32'd0);
        check("por.err", {31'd0, sb_bus.sb_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        //   name        iv rwe rd    pwe pn    wbv    wb0   wb1   pwbv   pw0   pw1   reg           pred    err
        // Single issue/retire of r5.
        step("r5_iss",   1, 1, 5'd5,  0, 2'd0, 2'b00, 5'd0, 5'd0, 2'b00, 2'd0, 2'd0, 32'h20,       3'b000, 0);
        step("r5_hold1", 0, 0, 5'd0,  0, 2'd0, 2'b00, 5'd0, 5'd0, 2'b00, 2'd0, 2'd0, 32'h20,       3'b000, 0);
        step("r5_hold2", 0, 0, 5'd0,  0, 2'd0, 2'b00, 5'd0, 5'd0, 2'b00, 2'd0, 2'd0, 32'h20,       3'b000, 0);
        step("r5_ret",   0, 0, 5'd0,  0, 2'd0, 2'b01, 5'd5, 5'd0, 2'b00, 2'd0, 2'd0, 32'h0,        3'b000, 0);
        // Overlapping issue and retire of r7 nets out.
        step("r7_iss",   1, 1, 5'd7,  0, 2'd0, 2'b00, 5'd0, 5'd0, 2'b00, 2'd0, 2'd0, 32'h80,       3'b000, 0);
        step("r7_net",   1, 1, 5'd7,  0, 2'd0, 2'b01, 5'd7, 5'd0, 2'b00, 2'd0, 2'd0, 32'h80,       3'b000, 0);
        step("r7_hold",  0, 0, 5'd0,  0, 2'd0, 2'b00, 5'd0, 5'd0, 2'b00, 2'd0, 2'd0, 32'h80,       3'b000, 0);
        step("r7_ret1",  0, 0, 5'd0,  0, 2'd0, 2'b10, 5'd0, 5'd7, 2'b00, 2'd0, 2'd0, 32'h0,        3'b000, 0);
        // Dual-port retire of r9 at count 2.
        step("r9_iss1",  1, 1, 5'd9,  0, 2'd0, 2'b00, 5'd0, 5'd0, 2'b00, 2'd0, 2'd0, 32'h200,      3'b000, 0);
        step("r9_iss2",  1, 1, 5'd9,  0, 2'd0, 2'b00, 5'd0, 5'd0, 2'b00, 2'd0, 2'd0, 32'h200,      3'b000, 0);
        step("r9_dual",  0, 0, 5'd0,  0, 2'd0, 2'b11, 5'd9, 5'd9, 2'b00, 2'd0, 2'd0, 32'h0,        3'b000, 0);
        // Gated strobes have no effect.
        step("gated",    0, 1, 5'd4,  1, 2'd1, 2'b00, 5'd9, 5'd9, 2'b00, 2'd1, 2'd1, 32'h0,        3'b000, 0);
        // Predicates, including the hardwired-true predicate 3.
        step("p1_iss",   1, 0, 5'd0,  1, 2'd1, 2'b00, 5'd0, 5'd0, 2'b00, 2'd0, 2'd0, 32'h0,        3'b010, 0);
        step("p3_iss",   1, 0, 5'd0,  1, 2'd3, 2'b00, 5'd0, 5'd0, 2'b00, 2'd0, 2'd0, 32'h0,        3'b010, 0);
        step("p3_ret",   0, 0, 5'd0,  0, 2'd0, 2'b00, 5'd0, 5'd0, 2'b11, 2'd3, 2'd3, 32'h0,        3'b010, 0);
        step("p1_ret",   0, 0, 5'd0,  0, 2'd0, 2'b00, 5'd0, 5'd0, 2'b10, 2'd0, 2'd1, 32'h0,        3'b000, 0);
        // GPR and predicate write from one instruction.
        step("both_iss", 1, 1, 5'd2,  1, 2'd0, 2'b00, 5'd0, 5'd0, 2'b00, 2'd0, 2'd0, 32'h4,        3'b001, 0);
        step("both_ret", 0, 0, 5'd0,  0, 2'd0, 2'b01, 5'd2, 5'd0, 2'b01, 2'd0, 2'd0, 32'h0,        3'b000, 0);
        // Overflow of r3 (max 3).
        step("r3_iss1",  1, 1, 5'd3,  0, 2'd0, 2'b00, 5'd0, 5'd0, 2'b00, 2'd0, 2'd0, 32'h8,        3'b000, 0);
        step("r3_iss2",  1, 1, 5'd3,  0, 2'd0, 2'b00, 5'd0, 5'd0, 2'b00, 2'd0, 2'd0, 32'h8,        3'b000, 0);
        step("r3_iss3",  1, 1, 5'd3,  0, 2'd0, 2'b00, 5'd0, 5'd0, 2'b00, 2'd0, 2'd0, 32'h8,        3'b000, 0);
        step("r3_ovf",   1, 1, 5'd3,  0, 2'd0, 2'b00, 5'd0, 5'd0, 2'b00, 2'd0, 2'd0, 32'h8,        3'b000, 1);
        step("r3_ret1",  0, 0, 5'd0,  0, 2'd0, 2'b01, 5'd3, 5'd0, 2'b00, 2'd0, 2'd0, 32'h8,        3'b000, 1);
        step("r3_ret2",  0, 0, 5'd0,  0, 2'd0, 2'b01, 5'd3, 5'd0, 2'b00, 2'd0, 2'd0, 32'h8,        3'b000, 1);
        step("r3_ret3",  0, 0, 5'd0,  0, 2'd0, 2'b01, 5'd3, 5'd0, 2'b00, 2'd0, 2'd0, 32'h0,        3'b000, 1);
        drain();
        async_reset("rst1");

        // Underflow of r3 from count 0.
        step("r3_unf",   0, 0, 5'd0,  0, 2'd0, 2'b01, 5'd3, 5'd0, 2'b00, 2'd0, 2'd0, 32'h0,        3'b000, 1);
        step("r3_stick", 0, 0, 5'd0,  0, 2'd0, 2'b00, 5'd0, 5'd0, 2'b00, 2'd0, 2'd0, 32'h0,        3'b000, 1);
        drain();
        async_reset("rst2");

        // Mid-operation async reset forgets r0, r31, pred 0.
        step("r0_iss",   1, 1, 5'd0,  0, 2'd0, 2'b00, 5'd0, 5'd0, 2'b00, 2'd0, 2'd0, 32'h1,        3'b000, 0);
        step("r31_iss",  1, 1, 5'd31, 1, 2'd0, 2'b00, 5'd0, 5'd0, 2'b00, 2'd0, 2'd0, 32'h80000001, 3'b001, 0);
        drain();
        async_reset("rst3");
        step("r31_unf",  0, 0, 5'd0,  0, 2'd0, 2'b01, 5'd31, 5'd0, 2'b00, 2'd0, 2'd0, 32'h0,       3'b000, 1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "timeout");
    end

endmodule
